seq_detect_param: RTL and testbench

Parametrised serial bit-pattern detector. It compares a single-bit input stream against a compile-time pattern of `LEN` bits, with overlap or non-overlap matching selected at run time. It produces a registered one-cycle match pulse and a saturating match counter. It is the general-purpose successor to the fixed 5-bit Mealy detectors in the serial-protocol front end, and it adds a bit-enable qualifier, counting and mode selection.

---
 rtl/seq_detect_param.sv | 62 ++++++
 tb/tb_seq_detect_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector, overlap/non-overlap, registered
// match pulse z and saturating match counter match_cnt.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   en         bit-valid qualifier, x is taken only when en=1
//   x          serial data bit
//   overlap    1 = overlapping matches, 0 = each match needs LEN fresh bits
//   clr_cnt    synchronous clear of match_cnt (wins over a same-edge match)
//   z          one-cycle match pulse, registered
//   match_cnt  saturating count of matches since reset or clear
module seq_detect_param #(
    parameter int              LEN     = 5,
    parameter logic [LEN-1:0]  PATTERN = 5'b10011,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(LEN);
    localparam logic [FW-1:0] FULL = FW'(LEN - 1);

    logic [LEN-2:0] win;
    logic [FW-1:0]  fill;
    logic [LEN-1:0] cand;
    logic           match;

    assign cand  = {win, x};
    assign match = en && (fill == FULL) && (cand == PATTERN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            win       <= '0;
            fill      <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
        end else begin
            z <= match;
            if (en) begin
                win <= cand[LEN-2:0];
                // Non-overlap mode forgets the window after a hit.
                if (match && !overlap)
                    fill <= '0;
                else if (fill != FULL)
                    fill <= fill + FW'(1);
            end
            if (clr_cnt)
                match_cnt <= '0;
            else if (match && (match_cnt != '1))
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic,
// three instances checked against a bit-history reference model.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic reset_n, en, x, overlap, clr_cnt;
    logic       z0, z1, z2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_param dut0 (
        .clk(clk), .reset_n(reset_n), .en(en), .x(x),
        .overlap(overlap), .clr_cnt(clr_cnt),
        .z(z0), .match_cnt(c0)
    );

    seq_detect_param #(.LEN(4), .PATTERN(4'b1111), .CNT_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .x(x),
        .overlap(overlap), .clr_cnt(clr_cnt),
        .z(z1), .match_cnt(c1)
    );

    seq_detect_param #(.LEN(5), .PATTERN(5'b10011), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .x(x),
        .overlap(overlap), .clr_cnt(clr_cnt),
        .z(z2), .match_cnt(c2)
    );

    // Reference state: accepted bits since the last reset or
    // non-overlap hit, oldest first.
    bit q0[$];
    bit q1[$];
    bit q2[$];
    int ec0, ec1, ec2;
    bit ez0, ez1, ez2;
    int p0, p1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mstep(inout bit q[$], inout int cnt, output bit zz,
                         input int len, input int pat, input int cmax);
        bit hit;
        hit = 1'b0;
        if (en) begin
            q.push_back(x);
            if (q.size() > len) void'(q.pop_front());
            if (q.size() == len) begin
                hit = 1'b1;
                for (int i = 0; i < len; i++)
                    if (q[i] != pat[len-1-i]) hit = 1'b0;
            end
            if (hit && !overlap) q.delete();
        end
        zz = hit;
        if (hit && cnt < cmax) cnt++;
        if (clr_cnt) cnt = 0;
    endtask

    task automatic cyc();
        if (!reset_n) begin
            q0.delete(); q1.delete(); q2.delete();
            ec0 = 0; ec1 = 0; ec2 = 0;
            ez0 = 0; ez1 = 0; ez2 = 0;
        end else begin
            mstep(q0, ec0, ez0, 5, 5'b10011, 255);
            mstep(q1, ec1, ez1, 4, 4'b1111, 255);
            mstep(q2, ec2, ez2, 5, 5'b10011, 3);
        end
        @(posedge clk);
        #1;
        chk("z_p5", z0, ez0);
        chk("cnt_p5", c0, ec0);
        chk("z_p4", z1, ez1);
        chk("cnt_p4", c1, ec1);
        chk("z_c2", z2, ez2);
        chk("cnt_c2", c2, ec2);
        p0 += int'(z0);
        p1 += int'(z1);
    endtask

    task automatic send(input bit b);
        en = 1'b1;
        x  = b;
        cyc();
    endtask

    task automatic idle();
        en = 1'b0;
        x  = 1'($urandom_range(0, 1));
        cyc();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en      = 1'b0;
        clr_cnt = 1'b0;
        cyc();
        reset_n = 1'b1;
        p0 = 0;
        p1 = 0;
    endtask

    task automatic send_pat();
        send(1); send(0); send(0); send(1); send(1);
    endtask

    initial begin
        int sat[5];
        sat = '{1, 2, 3, 3, 3};
        ec0 = 0; ec1 = 0; ec2 = 0;
        p0 = 0; p1 = 0;
        reset_n = 1'b0;
        en = 1'b1;
        x = 1'b1;
        overlap = 1'b1;
        clr_cnt = 1'b0;

        // Reset held with active inputs.
        repeat (3) begin
            cyc();
            chk("rst_z", z0, 0);
            chk("rst_cnt", c0, 0);
        end
        reset_n = 1'b1;
        cyc();
        chk("rel_z", z0, 0);
        chk("rel_cnt", c0, 0);

        // Overlap on default pattern.
        do_reset();
        overlap = 1'b1;
        send_pat(); send(0); send(0); send(1); send(1);
        chk("ov1_cnt", c0, 2);
        chk("ov1_pulses", p0, 2);

        do_reset();
        overlap = 1'b0;
        send_pat(); send(0); send(0); send(1); send(1);
        chk("ov0_cnt", c0, 1);
        chk("ov0_pulses", p0, 1);

        // Run of seven ones on the LEN=4 instance.
        do_reset();
        overlap = 1'b1;
        repeat (7) send(1);
        chk("ones_ov1_cnt", c1, 4);
        chk("ones_ov1_pulses", p1, 4);

        do_reset();
        overlap = 1'b0;
        repeat (7) send(1);
        chk("ones_ov0_cnt", c1, 1);
        chk("ones_ov0_pulses", p1, 1);

        // Enable gaps between bits.
        do_reset();
        overlap = 1'b1;
        send(1);
        idle(); idle(); send(0);
        idle(); idle(); send(0);
        idle(); idle(); send(1);
        idle(); idle(); send(1);
        chk("gap_z", z0, 1);
        idle();
        chk("gap_idle_z", z0, 0);
        chk("gap_pulses", p0, 1);

        // Reset mid-pattern discards history.
        do_reset();
        send(1); send(0); send(0);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        send(1); send(1);
        chk("midrst_pulses", p0, 0);
        send_pat();
        chk("midrst_after", p0, 1);
        chk("midrst_cnt", c0, 1);

        // Saturation and clear priority on the 2-bit counter.
        do_reset();
        overlap = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_pat();
            chk("sat_cnt", c2, sat[k]);
        end
        send(1); send(0); send(0); send(1);
        clr_cnt = 1'b1;
        send(1);
        chk("clr_z", z2, 1);
        chk("clr_cnt", c2, 0);
        clr_cnt = 1'b0;

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            en      = ($urandom_range(0, 3) != 0);
            x       = 1'($urandom_range(0, 1));
            overlap = ($urandom_range(0, 7) != 0);
            clr_cnt = ($urandom_range(0, 63) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
